ram_cmd_arbiter: RTL and testbench
==================================

# ram_cmd_arbiter

Two-requester controller that shares the single 10-bit command port of the synchronous RAM (`din[9:8]` opcode: 00 set write address, 01 write data, 10 set read address, 11 read). It takes whole read/write transactions from two masters. It serialises each transaction into the RAM's command words and returns read data with a per-requester response. It sits between the requesters and the RAM's `din`/`rx_valid`/`dout`/`tx_valid` pins, and is the only driver of that port.

## Interface
- `TIMEOUT`, 4 — cycles waited in RD_WAIT for `ram_tx_valid` before an error response; range 1–15.
- `clk` in 1 — single clock, all logic on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `req_valid` in 2 — bit i: requester i presents a transaction.
- `req_ready` out 2 — bit i: transaction of requester i accepted this cycle.
- `req_wr` in 2 — bit i: 1 = write, 0 = read.
- `req_addr` in 16 — requester i address in `[8i+7:8i]`.
- `req_wdata` in 16 — requester i write data in `[8i+7:8i]`.
- `rsp_valid` out 2 — bit i: one-cycle read response pulse for requester i.
- `rsp_err` out 1 — qualifies `rsp_valid`; 1 = read timed out.
- `rsp_data` out 8 — read data; 0 when `rsp_err`.
- `ram_din` out 10 — command word to RAM.
- `ram_rx_valid` out 1 — command word valid.
- `ram_dout` in 8 — RAM read data.
- `ram_tx_valid` in 1 — RAM read data valid.

## Operation
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT.
- **IDLE**
  - Arbitrate among asserted `req_valid` bits.
  - `req_ready[g] = (state==IDLE) & grant[g]`, combinational; at most one bit is set.
  - On grant, latch the id, wr, addr and wdata. Write goes to WR_ADDR; read goes to RD_ADDR.
- **Round robin:** if both requesters are valid, grant the one not granted last. The last-grant pointer resets to 1, so requester 0 wins the first tie. A lone valid requester is always granted.
- **WR_ADDR:** `ram_din={2'b00,addr}`, `ram_rx_valid=1`, then WR_DATA.
- **WR_DATA:** `{2'b01,wdata}`, then IDLE. Writes produce no response.
- **RD_ADDR:** `{2'b10,addr}`, then RD_CMD.
- **RD_CMD:** `{2'b11,8'h00}`, then RD_WAIT; clear the timeout counter.
- **RD_WAIT:** `ram_rx_valid=0`.
  - If `ram_tx_valid`: register `rsp_data=ram_dout`, pulse `rsp_valid[id]` next cycle with `rsp_err=0`, go to IDLE.
  - Else increment the counter. When the count reaches TIMEOUT: pulse `rsp_valid[id]` with `rsp_err=1`, `rsp_data=0`, go to IDLE.
- Outside the command states, `ram_rx_valid=0` and `ram_din=0`.
- A requester must hold its `req_*` stable while `req_valid` is high and `req_ready` is low.

## Timing
- **Reset values:** `req_ready=0`, `rsp_valid=0`, `rsp_err=0`, `rsp_data=0`, `ram_din=0`, `ram_rx_valid=0`. State is IDLE, the counter is 0 and the address-cache valids are 0.
- **Write:** accepted at cycle 0; command words in cycles 1–2; next accept possible at cycle 3.
- **Read:** accepted at cycle 0; words in cycles 1–2. `ram_tx_valid` arrives in cycle 3 and `rsp_valid` is high in cycle 4; next accept possible at cycle 4.
- A `rsp_valid` pulse and a new `req_ready` may occur in the same cycle.
- **Reset mid-transaction:** the next cycle is IDLE with `ram_rx_valid=0`. The pending transaction is dropped with no response.
- **`ram_tx_valid` outside RD_WAIT:** ignored. The RAM holds tx_valid high until its next command, so this is legal.

## Configuration
- **`ADDR_CACHE_EN` defined:**
  - Keep `last_wr_addr` and `last_rd_addr`, each with a valid bit.
  - A write whose address equals a valid `last_wr_addr` skips WR_ADDR (IDLE→WR_DATA, 2-cycle write).
  - A read whose address equals a valid `last_rd_addr` skips RD_ADDR (response at cycle 3).
  - The cache is updated when an address word issues. Valids clear on `rst`.
- **Not defined:** no cache logic; every transaction issues its address word.

## Test plan
- **Write then read, requester 0:** write addr 0x12 data 0xA5, then read 0x12. Response: `ram_din` sequence 0x012, 0x1A5, 0x212, 0x300; `rsp_valid=2'b01`, `rsp_data=0xA5`, `rsp_err=0`, in cycle 4 of the read.
- **Simultaneous requests:** both requesters assert reads (addr 0x01 / 0x02) in the first cycle after reset. Response: grant order is 0, then 1; `rsp_valid` goes 01 then 10, with the correct data each time.
- **Fairness:** requester 0 holds valid continuously while requester 1 requests once. Response: requester 1 is granted on the next arbitration; grants alternate 0,1,0.
- **Timeout:** the bench ties `ram_tx_valid=0`. Response: `rsp_err=1`, `rsp_data=0` exactly TIMEOUT+1 cycles after RD_WAIT entry, then the block returns to IDLE.
- **Reset mid-read:** assert `rst` in RD_CMD. Response: the next cycle has `ram_rx_valid=0` and no `rsp_valid`; the next request is serviced normally.
- **`ADDR_CACHE_EN`:** two writes to 0x40 (data 0x11, 0x22). Response: the second issues only 0x122; with the macro off, it issues 0x040, 0x122.

Source files
------------

// File: rtl/ram_cmd_arbiter_if.sv
// Requester and RAM command-port signals of ram_cmd_arbiter.
// slave is the arbiter's view; master is the view of whatever drives it (requesters plus RAM).
interface ram_cmd_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic        rsp_err;
  logic [7:0]  rsp_data;
  logic [9:0]  ram_din;
  logic        ram_rx_valid;
  logic [7:0]  ram_dout;
  logic        ram_tx_valid;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, ram_dout, ram_tx_valid,
    output req_ready, rsp_valid, rsp_err, rsp_data, ram_din, ram_rx_valid
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, ram_dout, ram_tx_valid,
    input  req_ready, rsp_valid, rsp_err, rsp_data, ram_din, ram_rx_valid
  );
endinterface

// File: rtl/ram_cmd_arbiter.sv
// Round-robin arbiter serialising two requesters' read/write transactions onto the RAM command port.
// Optional ADDR_CACHE_EN macro skips the address word when it repeats the last issued one.
module ram_cmd_arbiter #(
  parameter int TIMEOUT = 4
) (
  input  logic            clk,
  input  logic            rst,
  ram_cmd_arbiter_if.slave bus
);
  localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT} state_t;

  state_t      state_q, state_d;
  logic        id_q, id_d;
  logic        last_q, last_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic [9:0]  ram_din_q, ram_din_d;
  logic        ram_rx_valid_q, ram_rx_valid_d;

  logic [1:0]  grant;
  logic        gnt_id;
  logic        gnt_wr;
  logic [7:0]  gnt_addr;
  logic [7:0]  gnt_wdata;
  logic        wr_hit;
  logic        rd_hit;

  // On a tie, last_q==1 means requester 1 went last, so requester 0 wins.
  always_comb begin
    grant = bus.req_valid;
    if (bus.req_valid == 2'b11) grant = last_q ? 2'b01 : 2'b10;
  end

  assign gnt_id    = grant[1];
  assign gnt_wr    = gnt_id ? bus.req_wr[1] : bus.req_wr[0];
  assign gnt_addr  = gnt_id ? bus.req_addr[15:8] : bus.req_addr[7:0];
  assign gnt_wdata = gnt_id ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
  assign bus.req_ready = (state_q == IDLE) ? grant : 2'b00;

`ifdef ADDR_CACHE_EN
  logic [7:0] last_wr_addr_q, last_wr_addr_d;
  logic [7:0] last_rd_addr_q, last_rd_addr_d;
  logic       wr_cv_q, wr_cv_d;
  logic       rd_cv_q, rd_cv_d;

  assign wr_hit = wr_cv_q && (gnt_addr == last_wr_addr_q);
  assign rd_hit = rd_cv_q && (gnt_addr == last_rd_addr_q);

  always_comb begin
    last_wr_addr_d = last_wr_addr_q;
    last_rd_addr_d = last_rd_addr_q;
    wr_cv_d        = wr_cv_q;
    rd_cv_d        = rd_cv_q;
    if (state_q == WR_ADDR) begin
      last_wr_addr_d = addr_q;
      wr_cv_d        = 1'b1;
    end
    if (state_q == RD_ADDR) begin
      last_rd_addr_d = addr_q;
      rd_cv_d        = 1'b1;
    end
  end
`else
  assign wr_hit = 1'b0;
  assign rd_hit = 1'b0;
`endif

  // Outputs are computed for the state being entered so they appear registered alongside it.
  always_comb begin
    state_d        = state_q;
    id_d           = id_q;
    last_d         = last_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    cnt_d          = cnt_q;
    rsp_valid_d    = 2'b00;
    rsp_err_d      = 1'b0;
    rsp_data_d     = 8'h00;
    ram_din_d      = 10'h000;
    ram_rx_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          id_d           = gnt_id;
          last_d         = gnt_id;
          addr_d         = gnt_addr;
          wdata_d        = gnt_wdata;
          ram_rx_valid_d = 1'b1;
          if (gnt_wr) begin
            if (wr_hit) begin
              state_d   = WR_DATA;
              ram_din_d = {2'b01, gnt_wdata};
            end else begin
              state_d   = WR_ADDR;
              ram_din_d = {2'b00, gnt_addr};
            end
          end else if (rd_hit) begin
            state_d   = RD_CMD;
            ram_din_d = {2'b11, 8'h00};
          end else begin
            state_d   = RD_ADDR;
            ram_din_d = {2'b10, gnt_addr};
          end
        end
      end
      WR_ADDR: begin
        state_d        = WR_DATA;
        ram_rx_valid_d = 1'b1;
        ram_din_d      = {2'b01, wdata_q};
      end
      WR_DATA: state_d = IDLE;
      RD_ADDR: begin
        state_d        = RD_CMD;
        ram_rx_valid_d = 1'b1;
        ram_din_d      = {2'b11, 8'h00};
      end
      RD_CMD: begin
        state_d = RD_WAIT;
        cnt_d   = 4'd0;
      end
      RD_WAIT: begin
        if (bus.ram_tx_valid) begin
          state_d     = IDLE;
          rsp_valid_d = id_q ? 2'b10 : 2'b01;
          rsp_data_d  = bus.ram_dout;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d     = IDLE;
          rsp_valid_d = id_q ? 2'b10 : 2'b01;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      id_q           <= 1'b0;
      last_q         <= 1'b1;
      addr_q         <= 8'h00;
      wdata_q        <= 8'h00;
      cnt_q          <= 4'd0;
      rsp_valid_q    <= 2'b00;
      rsp_err_q      <= 1'b0;
      rsp_data_q     <= 8'h00;
      ram_din_q      <= 10'h000;
      ram_rx_valid_q <= 1'b0;
`ifdef ADDR_CACHE_EN
      last_wr_addr_q <= 8'h00;
      last_rd_addr_q <= 8'h00;
      wr_cv_q        <= 1'b0;
      rd_cv_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      id_q           <= id_d;
      last_q         <= last_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      cnt_q          <= cnt_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_err_q      <= rsp_err_d;
      rsp_data_q     <= rsp_data_d;
      ram_din_q      <= ram_din_d;
      ram_rx_valid_q <= ram_rx_valid_d;
`ifdef ADDR_CACHE_EN
      last_wr_addr_q <= last_wr_addr_d;
      last_rd_addr_q <= last_rd_addr_d;
      wr_cv_q        <= wr_cv_d;
      rd_cv_q        <= rd_cv_d;
`endif
    end
  end

  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.ram_din      = ram_din_q;
  assign bus.ram_rx_valid = ram_rx_valid_q;
endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Scoreboard bench for ram_cmd_arbiter with a behavioural RAM on the command port.
// Honours ADDR_CACHE_EN when predicting which address words are issued.
`timescale 1ns/1ps
module tb_ram_cmd_arbiter;
  localparam int TIMEOUT = 4;
`ifdef ADDR_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  typedef struct { int cyc; logic [9:0] word; } word_exp_t;
  typedef struct { int cyc; logic [1:0] vld; logic err; logic [7:0] data; } rsp_exp_t;
  typedef struct { logic wr; logic [7:0] addr; logic [7:0] data; } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   rst_at = -1;
  int   rst_off = -1;
  int   rel_cyc = 0;

  ram_cmd_arbiter_if bus();
  ram_cmd_arbiter #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  word_exp_t word_q[$];
  rsp_exp_t  rsp_q[$];
  txn_t      txq0[$];
  txn_t      txq1[$];
  int        grant_log[$];
  int        acc_log[$];
  logic [7:0] ref_mem [256];
  logic      m_wv, m_rv;
  logic [7:0] m_wa, m_ra;

  function automatic logic [7:0] init_val(input int a);
    return 8'(a * 37 + 11);
  endfunction

  // Behavioural RAM: reacts to the word seen at each edge, holds tx_valid until the next command.
  logic [7:0] ram_mem [256];
  logic [7:0] ram_wa = 8'h00;
  logic [7:0] ram_ra = 8'h00;
  logic       ram_tx = 1'b0;
  logic       ram_mute = 1'b0;
  logic       ram_init = 1'b0;
  logic       cmd_v;
  logic [9:0] cmd_w;
  always @(posedge clk) begin
    cmd_v = bus.ram_rx_valid;
    cmd_w = bus.ram_din;
    #1;
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram_mem[i] = init_val(i);
      ram_init = 1'b1;
    end
    if (cmd_v) begin
      case (cmd_w[9:8])
        2'b00: begin ram_wa = cmd_w[7:0]; ram_tx = 1'b0; end
        2'b01: begin ram_mem[ram_wa] = cmd_w[7:0]; ram_tx = 1'b0; end
        2'b10: begin ram_ra = cmd_w[7:0]; ram_tx = 1'b0; end
        default: begin ram_tx = 1'b1; bus.ram_dout = ram_mem[ram_ra]; end
      endcase
    end
    bus.ram_tx_valid = ram_tx & ~ram_mute;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int acc_at(input int i);
    if (i < acc_log.size()) return acc_log[i];
    return -1;
  endfunction

  function automatic int grant_at(input int i);
    if (i < grant_log.size()) return grant_log[i];
    return -1;
  endfunction

  task automatic push_word(input int c, input logic [9:0] w);
    word_exp_t e;
    e.cyc = c; e.word = w;
    word_q.push_back(e);
  endtask

  task automatic push_rsp(input int c, input int id, input logic err, input logic [7:0] d);
    rsp_exp_t e;
    e.cyc = c; e.vld = (id == 1) ? 2'b10 : 2'b01; e.err = err; e.data = d;
    rsp_q.push_back(e);
  endtask

  task automatic add_txn(input int id, input logic wr, input logic [7:0] a, input logic [7:0] d);
    txn_t t;
    t.wr = wr; t.addr = a; t.data = d;
    if (id == 1) txq1.push_back(t);
    else txq0.push_back(t);
  endtask

  task automatic on_accept(input int id, input txn_t t);
    int  c;
    int  entry;
    bit  hit;
    c = cyc;
    grant_log.push_back(id);
    acc_log.push_back(c);
    if (rst_off >= 0 && rst_at < 0) rst_at = c + rst_off;
    if (t.wr) begin
      hit = CACHE_EN && m_wv && (m_wa == t.addr);
      if (!hit) begin
        push_word(c + 1, {2'b00, t.addr});
        m_wv = 1'b1; m_wa = t.addr;
      end
      push_word(hit ? c + 1 : c + 2, {2'b01, t.data});
      ref_mem[t.addr] = t.data;
    end else begin
      hit = CACHE_EN && m_rv && (m_ra == t.addr);
      if (!hit) begin
        push_word(c + 1, {2'b10, t.addr});
        m_rv = 1'b1; m_ra = t.addr;
      end
      push_word(hit ? c + 1 : c + 2, 10'h300);
      entry = hit ? c + 2 : c + 3;
      if (ram_mute) push_rsp(entry + TIMEOUT + 1, id, 1'b1, 8'h00);
      else push_rsp(entry + 1, id, 1'b0, ref_mem[t.addr]);
    end
  endtask

  task automatic monitor();
    word_exp_t we;
    rsp_exp_t  re;
    if (bus.ram_rx_valid) begin
      if (word_q.size() == 0) begin
        check_val("unexp_word", {21'b0, bus.ram_rx_valid, bus.ram_din}, 32'h0);
      end else begin
        we = word_q.pop_front();
        check_val("word", {22'b0, bus.ram_din}, {22'b0, we.word});
        check_val("word_cyc", cyc, we.cyc);
      end
    end else begin
      check_val("din_idle", {22'b0, bus.ram_din}, 32'h0);
    end
    if (bus.rsp_valid != 2'b00) begin
      if (rsp_q.size() == 0) begin
        check_val("unexp_rsp", {30'b0, bus.rsp_valid}, 32'h0);
      end else begin
        re = rsp_q.pop_front();
        check_val("rsp_valid", {30'b0, bus.rsp_valid}, {30'b0, re.vld});
        check_val("rsp_err", {31'b0, bus.rsp_err}, {31'b0, re.err});
        check_val("rsp_data", {24'b0, bus.rsp_data}, {24'b0, re.data});
        check_val("rsp_cyc", cyc, re.cyc);
      end
    end
  endtask

  // Entered and left at posedge+1; inputs only change there.
  task automatic run(input int max_cyc);
    int          start;
    logic [1:0]  rv, rw;
    logic [15:0] ra, rd;
    start = cyc;
    forever begin
      rv = '0; rw = '0; ra = '0; rd = '0;
      if (txq0.size() > 0) begin
        rv[0] = 1'b1; rw[0] = txq0[0].wr; ra[7:0] = txq0[0].addr; rd[7:0] = txq0[0].data;
      end
      if (txq1.size() > 0) begin
        rv[1] = 1'b1; rw[1] = txq1[0].wr; ra[15:8] = txq1[0].addr; rd[15:8] = txq1[0].data;
      end
      bus.req_valid = rv; bus.req_wr = rw; bus.req_addr = ra; bus.req_wdata = rd;
      rst = (cyc == rst_at);
      @(negedge clk);
      monitor();
      if (rst_at >= 0 && cyc == rst_at + 1) begin
        check_val("rst_mid_rx_valid", {31'b0, bus.ram_rx_valid}, 32'h0);
        check_val("rst_mid_rsp_valid", {30'b0, bus.rsp_valid}, 32'h0);
      end
      check_val("ready_onehot", {31'b0, ($countones(bus.req_ready) <= 1)}, 32'h1);
      if (bus.req_ready[0]) begin
        if (txq0.size() == 0) check_val("unexp_ready0", {31'b0, bus.req_ready[0]}, 32'h0);
        else on_accept(0, txq0.pop_front());
      end
      if (bus.req_ready[1]) begin
        if (txq1.size() == 0) check_val("unexp_ready1", {31'b0, bus.req_ready[1]}, 32'h0);
        else on_accept(1, txq1.pop_front());
      end
      if (cyc == rst_at) begin
        word_q.delete(); rsp_q.delete();
        m_wv = 1'b0; m_rv = 1'b0;
      end
      if (txq0.size() == 0 && txq1.size() == 0 && word_q.size() == 0 && rsp_q.size() == 0 &&
          (rst_at < 0 || cyc > rst_at)) break;
      if (cyc - start >= max_cyc) begin
        check_val("run_budget", txq0.size() + txq1.size() + word_q.size() + rsp_q.size(), 32'h0);
        txq0.delete(); txq1.delete(); word_q.delete(); rsp_q.delete();
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    rst_at = -1;
    rst_off = -1;
    @(posedge clk);
    @(negedge clk);
    check_val("rst_req_ready", {30'b0, bus.req_ready}, 32'h0);
    check_val("rst_rsp_valid", {30'b0, bus.rsp_valid}, 32'h0);
    check_val("rst_rsp_err", {31'b0, bus.rsp_err}, 32'h0);
    check_val("rst_rsp_data", {24'b0, bus.rsp_data}, 32'h0);
    check_val("rst_ram_din", {22'b0, bus.ram_din}, 32'h0);
    check_val("rst_rx_valid", {31'b0, bus.ram_rx_valid}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    word_q.delete(); rsp_q.delete(); grant_log.delete(); acc_log.delete();
    m_wv = 1'b0; m_rv = 1'b0;
    rel_cyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0; bus.req_wr = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.ram_tx_valid = 1'b0; bus.ram_dout = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    @(posedge clk);
    #1;

    // write then read on requester 0
    apply_reset();
    add_txn(0, 1'b1, 8'h12, 8'hA5);
    add_txn(0, 1'b0, 8'h12, 8'h00);
    run(40);
    check_val("t1_rd_gap", acc_at(1) - acc_at(0), 3);

    // simultaneous reads right after reset
    apply_reset();
    add_txn(0, 1'b0, 8'h01, 8'h00);
    add_txn(1, 1'b0, 8'h02, 8'h00);
    run(40);
    check_val("t2_first_accept", acc_at(0), rel_cyc);
    check_val("t2_grant0", grant_at(0), 0);
    check_val("t2_grant1", grant_at(1), 1);
    check_val("t2_gap", acc_at(1) - acc_at(0), 4);

    // fairness: requester 0 stays valid, requester 1 asks once
    apply_reset();
    add_txn(0, 1'b0, 8'h05, 8'h00);
    add_txn(0, 1'b0, 8'h06, 8'h00);
    add_txn(1, 1'b0, 8'h07, 8'h00);
    run(60);
    check_val("t3_grant0", grant_at(0), 0);
    check_val("t3_grant1", grant_at(1), 1);
    check_val("t3_grant2", grant_at(2), 0);

    // read timeout, then a write to show the return to IDLE
    apply_reset();
    ram_mute = 1'b1;
    add_txn(0, 1'b0, 8'h30, 8'h00);
    add_txn(0, 1'b1, 8'h31, 8'h5C);
    run(60);
    ram_mute = 1'b0;
    check_val("t4_next_accept", acc_at(1) - acc_at(0), TIMEOUT + 4);

    // reset while in RD_CMD, then a normal read
    apply_reset();
    rst_off = 2;
    add_txn(0, 1'b0, 8'h12, 8'h00);
    run(40);
    rst_off = -1;
    rst_at = -1;
    add_txn(1, 1'b0, 8'h12, 8'h00);
    run(40);

    // repeated addresses (address cache when enabled)
    apply_reset();
    add_txn(0, 1'b1, 8'h40, 8'h11);
    add_txn(0, 1'b1, 8'h40, 8'h22);
    add_txn(0, 1'b0, 8'h40, 8'h00);
    add_txn(0, 1'b0, 8'h40, 8'h00);
    run(60);
    check_val("t6_wr2_gap", acc_at(1) - acc_at(0), 3);
    check_val("t6_rd2_gap", acc_at(3) - acc_at(2), 4);

    // random mix over a small address set
    apply_reset();
    for (int i = 0; i < 24; i++)
      add_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'h40 + 8'($urandom_range(0, 3)), 8'($urandom));
    run(2000);
    check_val("t7_accepts", acc_log.size(), 24);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
